// File: rtl/rr_select_pkg.sv
// Shared constants, FSM state type and the round-robin pick helper for rr_select_arbiter.
// Pure package: no latency or backpressure of its own.
package rr_select_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Returns {found, idx}: first full channel scanning last+1 .. last+4 (mod 4).
  // The scan runs from farthest to nearest so the nearest full channel wins.
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_CH-1:0] full,
                                             input logic [SEL_W-1:0]  last);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] idx;
    res = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      idx = last + SEL_W'(k);
      if (full[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_hold_slot.sv
// One-word valid/ready holding register; captures on valid&ready, word visible the next cycle.
// Ready only when empty or being consumed this cycle; held low during reset.
module rr_hold_slot #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             consume,
  input  logic [WIDTH-1:0] data,
  output logic             ready,
  output logic             full,
  output logic [WIDTH-1:0] held
);

  assign ready = !rst && (!full || consume);

  // A capture on the consume edge keeps the slot full with the new word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 1'b0;
      held <= '0;
    end else if (valid && ready) begin
      full <= 1'b1;
      held <= data;
    end else if (consume) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/rr_select_arbiter.sv
// Four-channel buffered round-robin feeder for the registered 4:1 selector; grant one cycle after capture,
// each grant held DWELL cycles then one IDLE bubble. Channels backpressure while their slot is full and unconsumed.
module rr_select_arbiter
  import rr_select_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DWELL = 1,
  parameter int CNT_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_CH-1:0]  i_valid,
  output logic [NUM_CH-1:0]  o_ready,
  input  logic [WIDTH-1:0]   i_data_0,
  input  logic [WIDTH-1:0]   i_data_1,
  input  logic [WIDTH-1:0]   i_data_2,
  input  logic [WIDTH-1:0]   i_data_3,
  output logic [SEL_W-1:0]   o_ctlr,
  output logic [WIDTH-1:0]   o_data_0,
  output logic [WIDTH-1:0]   o_data_1,
  output logic [WIDTH-1:0]   o_data_2,
  output logic [WIDTH-1:0]   o_data_3,
  output logic               o_sel_valid
);

  arb_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [SEL_W-1:0]  last_grant;
  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] consume;
  logic [SEL_W:0]    pick;
  logic [WIDTH-1:0]  in_data   [NUM_CH];
  logic [WIDTH-1:0]  slot_data [NUM_CH];

  assign in_data[0] = i_data_0;
  assign in_data[1] = i_data_1;
  assign in_data[2] = i_data_2;
  assign in_data[3] = i_data_3;

  assign o_data_0 = slot_data[0];
  assign o_data_1 = slot_data[1];
  assign o_data_2 = slot_data[2];
  assign o_data_3 = slot_data[3];

  for (genvar n = 0; n < NUM_CH; n++) begin : g_slot
    rr_hold_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk     (i_clk),
      .rst     (i_rst),
      .valid   (i_valid[n]),
      .consume (consume[n]),
      .data    (in_data[n]),
      .ready   (o_ready[n]),
      .full    (full[n]),
      .held    (slot_data[n])
    );
  end

  assign pick = rr_pick(full, last_grant);

  // Last dwell cycle of a grant frees the granted slot.
  always_comb begin
    consume = '0;
    if (state == GRANT && cnt == '0) consume[o_ctlr] = 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      last_grant  <= SEL_W'(NUM_CH - 1);
      o_ctlr      <= '0;
      o_sel_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick[SEL_W]) begin
            o_ctlr      <= pick[SEL_W-1:0];
            o_sel_valid <= 1'b1;
            cnt         <= CNT_W'(DWELL - 1);
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            last_grant  <= o_ctlr;
            o_sel_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Bench: three arbiters (DWELL 1, 3, 4) share random and directed stimulus and are compared every
// cycle against a slot/grant reference model; directed scenarios add fixed expected values.
module tb_rr_select_arbiter;

  localparam int NI = 3;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [3:0]  valid = '0;
  logic [15:0] din [4];

  logic [3:0]  rdy_o  [NI];
  logic [1:0]  ctlr_o [NI];
  logic        sv_o   [NI];
  logic [15:0] dat_o  [NI][4];

  int n_checks = 0;
  int n_err    = 0;

  always #5 i_clk = ~i_clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DWG = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    rr_select_arbiter #(.WIDTH(16), .DWELL(DWG), .CNT_W(8)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_valid     (valid),
      .o_ready     (rdy_o[g]),
      .i_data_0    (din[0]),
      .i_data_1    (din[1]),
      .i_data_2    (din[2]),
      .i_data_3    (din[3]),
      .o_ctlr      (ctlr_o[g]),
      .o_data_0    (dat_o[g][0]),
      .o_data_1    (dat_o[g][1]),
      .o_data_2    (dat_o[g][2]),
      .o_data_3    (dat_o[g][3]),
      .o_sel_valid (sv_o[g])
    );
  end

  // Reference model: buffered words per channel plus the current grant and its remaining cycles.
  logic [3:0]  m_full [NI];
  logic [15:0] m_data [NI][4];
  logic        m_busy [NI];
  int          m_left [NI];
  logic [1:0]  m_ctlr [NI];
  logic        m_sv   [NI];
  int          m_last [NI];

  function automatic int dw_of(int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  function automatic logic [3:0] m_cons(int k);
    logic [3:0] c;
    c = '0;
    if (m_busy[k] && m_left[k] == 1) c[m_ctlr[k]] = 1'b1;
    return c;
  endfunction

  function automatic logic [3:0] m_ready(int k);
    if (i_rst) return 4'h0;
    return ~m_full[k] | m_cons(k);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_full[k] = '0;
      for (int n = 0; n < 4; n++) m_data[k][n] = '0;
      m_busy[k] = 1'b0;
      m_left[k] = 0;
      m_ctlr[k] = '0;
      m_sv[k]   = 1'b0;
      m_last[k] = 3;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < NI; k++) begin
      logic [3:0] cons, rdy, f;
      bit found;
      int p;
      cons  = m_cons(k);
      rdy   = m_ready(k);
      f     = m_full[k];
      found = 0;
      p     = 0;
      for (int j = 1; j <= 4; j++) begin
        int c;
        c = (m_last[k] + j) % 4;
        if (!found && f[c]) begin
          found = 1;
          p     = c;
        end
      end
      for (int n = 0; n < 4; n++) begin
        if (valid[n] && rdy[n]) begin
          m_full[k][n] = 1'b1;
          m_data[k][n] = din[n];
        end else if (cons[n]) begin
          m_full[k][n] = 1'b0;
        end
      end
      if (m_busy[k]) begin
        if (m_left[k] == 1) begin
          m_busy[k] = 1'b0;
          m_sv[k]   = 1'b0;
          m_last[k] = int'(m_ctlr[k]);
        end else begin
          m_left[k] = m_left[k] - 1;
        end
      end else if (found) begin
        m_ctlr[k] = 2'(p);
        m_sv[k]   = 1'b1;
        m_busy[k] = 1'b1;
        m_left[k] = dw_of(k);
      end
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("i%0d ready", k), 32'(rdy_o[k]), 32'(m_ready(k)));
      check_eq($sformatf("i%0d ctlr", k), 32'(ctlr_o[k]), 32'(m_ctlr[k]));
      check_eq($sformatf("i%0d sel_valid", k), 32'(sv_o[k]), 32'(m_sv[k]));
      for (int n = 0; n < 4; n++)
        check_eq($sformatf("i%0d data%0d", k, n), 32'(dat_o[k][n]), 32'(m_data[k][n]));
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
    compare_all();
  endtask

  // Asserts reset mid-cycle so the asynchronous clear is observed before any clock edge.
  task automatic do_reset(input string tag);
    #2;
    i_rst = 1'b1;
    valid = '0;
    #1;
    model_reset();
    for (int k = 0; k < NI; k++) begin
      check_eq($sformatf("%s i%0d rst ready", tag, k), 32'(rdy_o[k]), 32'h0);
      check_eq($sformatf("%s i%0d rst sel_valid", tag, k), 32'(sv_o[k]), 32'h0);
    end
    compare_all();
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;
    for (int k = 0; k < NI; k++)
      check_eq($sformatf("%s i%0d ready after release", tag, k), 32'(rdy_o[k]), 32'hF);
    compare_all();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] grants[$];
    logic       prev_sv;

    for (int n = 0; n < 4; n++) din[n] = '0;
    model_reset();
    @(negedge i_clk);
    do_reset("t1");

    // Single word on ch2, DWELL=1 instance
    valid   = 4'b0100;
    din[2]  = 16'hA5A5;
    step();
    valid = '0;
    check_eq("t2 sv after E0", 32'(sv_o[0]), 32'h0);
    check_eq("t2 ready after E0", 32'(rdy_o[0]), 32'hB);
    step();
    check_eq("t2 sv at E1", 32'(sv_o[0]), 32'h1);
    check_eq("t2 ctlr at E1", 32'(ctlr_o[0]), 32'h2);
    check_eq("t2 ready in grant", 32'(rdy_o[0]), 32'hF);
    check_eq("t2 data2", 32'(dat_o[0][2]), 32'hA5A5);
    step();
    check_eq("t2 sv after grant", 32'(sv_o[0]), 32'h0);

    // All four full at once: strict rotation with IDLE bubbles
    do_reset("t3");
    valid = 4'hF;
    for (int n = 0; n < 4; n++) din[n] = 16'h1000 + 16'(n);
    step();
    valid = '0;
    for (int c = 1; c <= 8; c++) begin
      step();
      check_eq($sformatf("t3 sv c%0d", c), 32'(sv_o[0]), 32'(c % 2));
      if (c % 2 == 1) check_eq($sformatf("t3 ctlr c%0d", c), 32'(ctlr_o[0]), 32'((c - 1) / 2));
    end

    // DWELL=3: held word stable while the producer keeps offering, new word taken at consume edge
    do_reset("t4");
    valid  = 4'b0010;
    din[1] = 16'h1111;
    step();
    for (int c = 1; c <= 4; c++) begin
      din[1] = 16'h2000 + 16'(c);
      step();
      if (c <= 3) begin
        check_eq($sformatf("t4 sv c%0d", c), 32'(sv_o[1]), 32'h1);
        check_eq($sformatf("t4 ctlr c%0d", c), 32'(ctlr_o[1]), 32'h1);
        check_eq($sformatf("t4 data1 c%0d", c), 32'(dat_o[1][1]), 32'h1111);
      end else begin
        check_eq("t4 sv after dwell", 32'(sv_o[1]), 32'h0);
        check_eq("t4 data1 recaptured", 32'(dat_o[1][1]), 32'h2004);
      end
    end
    valid = '0;

    // Fairness: ch0 re-offers continuously, ch1 offers once
    do_reset("t5");
    valid   = 4'b0011;
    din[0]  = 16'h0A00;
    din[1]  = 16'h0B00;
    prev_sv = 1'b0;
    step();
    valid = 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      din[0] = 16'h0A00 + 16'(c);
      step();
      if (sv_o[0] && !prev_sv) grants.push_back(ctlr_o[0]);
      prev_sv = sv_o[0];
    end
    valid = '0;
    check_eq("t5 grant count", 32'(grants.size() >= 3), 32'h1);
    for (int i = 0; i < 3; i++)
      check_eq($sformatf("t5 grant%0d", i), 32'((i < grants.size()) ? grants[i] : 2'd3),
               32'((i == 1) ? 1 : 0));

    // Reset in the middle of a DWELL=4 grant
    do_reset("t6a");
    valid  = 4'b0010;
    din[1] = 16'hCAFE;
    step();
    valid = '0;
    step();
    check_eq("t6 sv cnt3", 32'(sv_o[2]), 32'h1);
    step();
    check_eq("t6 sv cnt2", 32'(sv_o[2]), 32'h1);
    do_reset("t6b");
    valid = 4'hF;
    for (int n = 0; n < 4; n++) din[n] = 16'h3000 + 16'(n);
    step();
    valid = '0;
    step();
    check_eq("t6 first grant sv", 32'(sv_o[2]), 32'h1);
    check_eq("t6 first grant ch0", 32'(ctlr_o[2]), 32'h0);

    // Random traffic with varying density and occasional mid-run resets
    for (int c = 0; c < 3000; c++) begin
      int dens;
      dens = (c / 250) % 4;
      for (int n = 0; n < 4; n++) begin
        valid[n] = ($urandom_range(3, 0) < dens + 1) ? 1'b1 : 1'b0;
        din[n]   = 16'($urandom);
      end
      step();
      if (c % 700 == 699) do_reset("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
